// File: rtl/lr35902_oam_scan_pkg.sv
// Constants and types shared by the mode-2 object search and the pixel fetcher.
// Includes the scan state encoding, the buffer entry layout and the line hit test.
package lr35902_oam_scan_pkg;

  localparam int OAM_ENTRIES = 40;
  localparam int OBJ_MAX     = 10;
  localparam int OBJ_H_SHORT = 8;
  localparam int OBJ_H_TALL  = 16;
  localparam int Y_OFFSET    = 16;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_RD_Y = 2'd1,
    SCAN_RD_X = 2'd2,
    SCAN_LAST = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [5:0] index;
    logic [7:0] x;
    logic [3:0] row;
  } obj_entry_t;

  // A Y above ly+16 wraps to a large 9-bit value, so it never passes the height test.
  function automatic logic [8:0] obj_line_offset(input logic [7:0] ly, input logic [7:0] y);
    return {1'b0, ly} + 9'(Y_OFFSET) - {1'b0, y};
  endfunction

  function automatic logic obj_line_hit(input logic [8:0] d, input logic tall);
    logic hit;
    if (tall) begin
      hit = (d < 9'(OBJ_H_TALL));
    end else begin
      hit = (d < 9'(OBJ_H_SHORT));
    end
    return hit;
  endfunction

endpackage

// File: rtl/lr35902_obj_buf.sv
// Line object buffer: append-only register file with a fill count and asynchronous read.
// Writes beyond DEPTH entries are dropped; clr empties the buffer for a new line.
module lr35902_obj_buf
  import lr35902_oam_scan_pkg::*;
#(
  parameter int DEPTH = OBJ_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [17:0] wr_data,
  input  logic [3:0]  rd_sel,
  output logic [3:0]  count,
  output logic [17:0] rd_data
);

  logic [3:0]  count_r;
  logic [17:0] mem_r [DEPTH];
  logic        full_s;

  assign full_s = (count_r >= 4'(DEPTH));

  // Fill count: cleared by reset or clr, advanced on each accepted write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 4'd0;
    end else if (clr) begin
      count_r <= 4'd0;
    end else if (wr_en && !full_s) begin
      count_r <= count_r + 4'd1;
    end
  end

  // Entry storage: contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en && !clr && !full_s) begin
      mem_r[count_r] <= wr_data;
    end
  end

  assign count   = count_r;
  assign rd_data = (rd_sel < 4'(DEPTH)) ? mem_r[rd_sel] : 18'd0;

endmodule

// File: rtl/lr35902_oam_scan.sv
// PPU mode-2 object search: reads Y then X of every OAM entry (2 clk per entry) and
// latches the first OBJ_MAX objects that cover the sampled line into lr35902_obj_buf.
module lr35902_oam_scan
  import lr35902_oam_scan_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ly,
  input  logic       obj_tall,
  input  logic       dma_active,
  output logic [7:0] oam_adr,
  output logic       oam_read,
  input  logic [7:0] oam_din,
  output logic       busy,
  output logic       done,
  output logic [3:0] obj_count,
  input  logic [3:0] obj_sel,
  output logic [5:0] obj_index,
  output logic [7:0] obj_x,
  output logic [3:0] obj_row
);

  scan_state_t state_r, state_s;
  logic [5:0]  idx_r, idx_s;
  logic [7:0]  adr_s;
  logic        read_s;
  logic [7:0]  oam_adr_r;
  logic        oam_read_r, busy_r, done_r;
  logic [7:0]  ly_r, y_r;
  logic        tall_r, y_bad_r;
  logic [5:0]  y_idx_r;
  logic [7:0]  data_s;
  logic [8:0]  offset_s;
  logic        eval_s, hit_s;
  obj_entry_t  wr_entry_s, rd_entry_s;

  // Sequencer next state and next read address; start overrides everything.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    adr_s   = 8'd0;
    read_s  = 1'b0;
    if (start) begin
      state_s = SCAN_RD_Y;
      idx_s   = 6'd0;
    end else begin
      case (state_r)
        SCAN_IDLE: state_s = SCAN_IDLE;
        SCAN_RD_Y: state_s = SCAN_RD_X;
        SCAN_RD_X: begin
          if (idx_r == 6'(OAM_ENTRIES - 1)) begin
            state_s = SCAN_LAST;
          end else begin
            state_s = SCAN_RD_Y;
            idx_s   = idx_r + 6'd1;
          end
        end
        SCAN_LAST: state_s = SCAN_IDLE;
        default:   state_s = SCAN_IDLE;
      endcase
    end
    case (state_s)
      SCAN_RD_Y: begin
        adr_s  = {idx_s, 2'b00};
        read_s = 1'b1;
      end
      SCAN_RD_X: begin
        adr_s  = {idx_s, 2'b01};
        read_s = 1'b1;
      end
      default: begin
        adr_s  = 8'd0;
        read_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered OAM/handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= SCAN_IDLE;
      idx_r      <= 6'd0;
      oam_adr_r  <= 8'd0;
      oam_read_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      oam_adr_r  <= adr_s;
      oam_read_r <= read_s;
      busy_r     <= (state_s != SCAN_IDLE);
      done_r     <= (state_s == SCAN_LAST);
    end
  end

  // Line parameters are frozen at start; Y (and whether DMA hid it) is held for the X cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ly_r    <= 8'd0;
      tall_r  <= 1'b0;
      y_r     <= 8'd0;
      y_bad_r <= 1'b0;
      y_idx_r <= 6'd0;
    end else if (start) begin
      ly_r   <= ly;
      tall_r <= obj_tall;
    end else if (state_r == SCAN_RD_X) begin
      y_r     <= data_s;
      y_bad_r <= dma_active;
      y_idx_r <= idx_r;
    end
  end

  // X of the previous entry arrives in RD_Y (i>0) and in LAST; that is when the entry is judged.
  assign data_s   = dma_active ? 8'hFF : oam_din;
  assign eval_s   = ((state_r == SCAN_RD_Y) && (idx_r != 6'd0)) || (state_r == SCAN_LAST);
  assign offset_s = obj_line_offset(ly_r, y_r);
  assign hit_s    = eval_s && !start && !y_bad_r && !dma_active && obj_line_hit(offset_s, tall_r);

  assign wr_entry_s = '{index: y_idx_r, x: data_s, row: offset_s[3:0]};

  lr35902_obj_buf #(
    .DEPTH (OBJ_MAX)
  ) u_obj_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .wr_en   (hit_s),
    .wr_data (wr_entry_s),
    .rd_sel  (obj_sel),
    .count   (obj_count),
    .rd_data (rd_entry_s)
  );

  assign oam_adr   = oam_adr_r;
  assign oam_read  = oam_read_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign obj_index = rd_entry_s.index;
  assign obj_x     = rd_entry_s.x;
  assign obj_row   = rd_entry_s.row;

endmodule

// File: tb/tb_lr35902_oam_scan.sv
// Scoreboard bench for lr35902_oam_scan: scans push hand-computed results, a monitor
// checks them when done pulses; an OAM model answers reads one clock later.
module tb_lr35902_oam_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ly = 8'd0;
  logic       obj_tall = 1'b0;
  logic       dma_active = 1'b0;
  logic [7:0] oam_adr;
  logic       oam_read;
  logic [7:0] oam_din = 8'd0;
  logic       busy, done;
  logic [3:0] obj_count;
  logic [3:0] obj_sel = 4'd0;
  logic [5:0] obj_index;
  logic [7:0] obj_x;
  logic [3:0] obj_row;

  lr35902_oam_scan dut (
    .clk(clk), .reset(reset), .start(start), .ly(ly), .obj_tall(obj_tall),
    .dma_active(dma_active), .oam_adr(oam_adr), .oam_read(oam_read), .oam_din(oam_din),
    .busy(busy), .done(done), .obj_count(obj_count), .obj_sel(obj_sel),
    .obj_index(obj_index), .obj_x(obj_x), .obj_row(obj_row)
  );

  always #20 clk = ~clk;

  typedef struct {
    int           done_cyc;
    int           count;
    logic [179:0] slots;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] oam [0:159];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         checked = 0;
  logic       log_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (oam_read) oam_din <= oam[oam_adr];
  end

  always @(negedge clk) begin
    if (log_en && oam_read) rd_q.push_back(oam_adr);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] ent(input int idx, input int x, input int row);
    return {6'(idx), 8'(x), 4'(row)};
  endfunction

  // Monitor: each done pulse pops one expected scan result and reads back the buffer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cyc", cyc, e.done_cyc);
          chk("busy_at_done", int'(busy), 1);
          chk("obj_count", int'(obj_count), e.count);
          for (int s = 0; s < e.count; s++) begin
            obj_sel = 4'(s);
            #1;
            chk($sformatf("slot%0d", s), int'({obj_index, obj_x, obj_row}),
                int'(e.slots[s*18 +: 18]));
          end
          checked++;
        end
      end
    end
  end

  // Must be called just after a negedge; returns at the following negedge.
  task automatic start_pulse(input logic [7:0] l, input logic t, output int t0);
    ly = l;
    obj_tall = t;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    ly = 8'hAA;
    obj_tall = ~t;
    chk("busy_rise", int'(busy), 1);
  endtask

  task automatic wait_checked(input int target);
    int n = 0;
    while (checked < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("scan_timeout", int'(checked >= target), 1);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic run_scan(input logic [7:0] l, input logic t, input exp_t e);
    int t0;
    int target;
    target = checked + 1;
    @(negedge clk);
    start_pulse(l, t, t0);
    e.done_cyc = t0 + 81;
    sb_q.push_back(e);
    wait_checked(target);
  endtask

  initial begin
    exp_t e;
    int   t0, t1, target;

    for (int i = 0; i < 160; i++) oam[i] = 8'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_oam_read", int'(oam_read), 0);
    chk("rst_oam_adr", int'(oam_adr), 0);
    chk("rst_obj_count", int'(obj_count), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: empty OAM, full address sequence
    log_en = 1'b1;
    e.count = 0; e.slots = '0;
    run_scan(8'd0, 1'b0, e);
    log_en = 1'b0;
    chk("read_count", rd_q.size(), 80);
    for (int i = 0; i < 80 && i < rd_q.size(); i++)
      chk($sformatf("rd_adr%0d", i), int'(rd_q[i]), 4 * (i / 2) + (i % 2));
    rd_q.delete();

    // 2: entry 3 Y=16 X=8, entry 7 Y=20 X=0
    oam[12] = 8'd16; oam[13] = 8'd8;
    oam[28] = 8'd20; oam[29] = 8'd0;
    e.count = 1; e.slots = '0; e.slots[0 +: 18] = ent(3, 8, 2);
    run_scan(8'd2, 1'b0, e);
    e.count = 2; e.slots = '0; e.slots[0 +: 18] = ent(3, 8, 5); e.slots[18 +: 18] = ent(7, 0, 1);
    run_scan(8'd5, 1'b0, e);

    // 3: height boundaries on entry 0
    for (int i = 0; i < 160; i++) oam[i] = 8'd0;
    oam[0] = 8'd9; oam[1] = 8'h20;
    e.count = 1; e.slots = '0; e.slots[0 +: 18] = ent(0, 32, 7);
    run_scan(8'd0, 1'b0, e);
    oam[0] = 8'd8;
    e.count = 0; e.slots = '0;
    run_scan(8'd0, 1'b0, e);
    e.count = 1; e.slots = '0; e.slots[0 +: 18] = ent(0, 32, 8);
    run_scan(8'd0, 1'b1, e);
    oam[0] = 8'd0;
    e.count = 0; e.slots = '0;
    run_scan(8'd0, 1'b1, e);

    // 4: every entry visible, buffer saturates at 10
    for (int i = 0; i < 40; i++) begin
      oam[4*i] = 8'd16;
      oam[4*i+1] = 8'(16 + i);
    end
    e.count = 10; e.slots = '0;
    for (int s = 0; s < 10; s++) e.slots[s*18 +: 18] = ent(s, 16 + s, 0);
    run_scan(8'd0, 1'b0, e);

    // 5: DMA over clk 20..30 hides entries 9..14
    log_en = 1'b1;
    target = checked + 1;
    e.count = 10; e.slots = '0;
    for (int s = 0; s < 9; s++) e.slots[s*18 +: 18] = ent(s, 16 + s, 0);
    e.slots[9*18 +: 18] = ent(15, 31, 0);
    @(negedge clk);
    start_pulse(8'd0, 1'b0, t0);
    e.done_cyc = t0 + 81;
    sb_q.push_back(e);
    while (cyc < t0 + 20) @(negedge clk);
    dma_active = 1'b1;
    while (cyc < t0 + 31) @(negedge clk);
    dma_active = 1'b0;
    wait_checked(target);
    log_en = 1'b0;
    chk("dma_read_count", rd_q.size(), 80);
    rd_q.delete();

    // 6: restart at clk 40 with a line that misses everything
    target = checked + 1;
    @(negedge clk);
    start_pulse(8'd0, 1'b0, t0);
    while (cyc < t0 + 40) @(negedge clk);
    start_pulse(8'd100, 1'b0, t1);
    e.count = 0; e.slots = '0; e.done_cyc = t0 + 121;
    sb_q.push_back(e);
    wait_checked(target);

    // reset low mid-scan
    @(negedge clk);
    start_pulse(8'd0, 1'b0, t0);
    while (cyc < t0 + 50) @(negedge clk);
    chk("pre_reset_count", int'(obj_count), 10);
    reset = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_obj_count", int'(obj_count), 0);
    chk("async_oam_read", int'(oam_read), 0);
    #5;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_resume_busy", int'(busy), 0);
    chk("no_resume_read", int'(oam_read), 0);
    repeat (100) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
